// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port front end for a byte-enabled data BRAM.
module dmem_arbiter #(
  parameter int AWIDTH = 14,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [31:0]       a_addr,
  input  logic              a_we,
  input  logic [2:0]        a_funct3,
  input  logic [31:0]       a_wdata,
  output logic              a_rvalid,
  output logic [31:0]       a_rdata,
  output logic              a_err,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [31:0]       b_addr,
  input  logic              b_we,
  input  logic [2:0]        b_funct3,
  input  logic [31:0]       b_wdata,
  output logic              b_rvalid,
  output logic [31:0]       b_rdata,
  output logic              b_err,
  output logic              mem_en,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [3:0]        mem_wen,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);
  typedef struct packed {
    logic       valid;
    logic       port;
    logic       is_load;
    logic [2:0] funct3;
    logic [1:0] off;
    logic       err;
  } resp_t;
  resp_t pipe [MEM_LATENCY];
  resp_t tail;
  logic last_b, acc, sel_b, we, illegal, misaligned, bad, issue, resp_on;
  logic [2:0] f3;
  logic [1:0] off;
  logic [3:0] mask;
  logic [31:0] addr, wdata, sh, ext, rdata;
  logic unused_addr_bits;
  assign a_ready = !rst && a_valid && (!b_valid || last_b);
  assign b_ready = !rst && b_valid && !a_ready;
  assign acc = a_ready || b_ready;
  assign sel_b = b_ready;
  assign we = sel_b ? b_we : a_we;
  assign f3 = sel_b ? b_funct3 : a_funct3;
  assign addr = sel_b ? b_addr : a_addr;
  assign wdata = sel_b ? b_wdata : a_wdata;
  assign off = addr[1:0];
  assign unused_addr_bits = ^addr[31:AWIDTH+2];
  // loads allow 000/001/010/100/101, stores only 000/001/010
  assign illegal = (f3[1:0] == 2'b11) || (we ? f3[2] : (f3 == 3'b110));
  assign misaligned = (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
  assign bad = illegal || misaligned;
  assign issue = acc && !bad;
  assign mask = f3[1:0] == 2'b00 ? 4'b0001 << off : f3[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
  assign mem_en = issue;
  assign mem_wen = (issue && we) ? mask : 4'b0000;
  assign mem_addr = issue ? addr[AWIDTH+1:2] : '0;
  assign mem_din = issue ? wdata << {off, 3'b000} : 32'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_LATENCY; i++) pipe[i] <= '0;
      last_b <= 1'b1;
    end else begin
      pipe[0] <= '{valid: acc, port: sel_b, is_load: !we, funct3: f3, off: off, err: bad};
      for (int i = 1; i < MEM_LATENCY; i++) pipe[i] <= pipe[i-1];
      if (acc) last_b <= sel_b;
    end
  end
  assign tail = pipe[MEM_LATENCY-1];
  assign sh = mem_dout >> {tail.off, 3'b000};
  assign ext = tail.funct3 == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
               tail.funct3 == 3'b100 ? {24'd0, sh[7:0]} :
               tail.funct3 == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
               tail.funct3 == 3'b101 ? {16'd0, sh[15:0]} : sh;
  // rst also masks a response already sitting at the pipeline tail
  assign resp_on = tail.valid && !rst;
  assign rdata = (resp_on && tail.is_load && !tail.err) ? ext : 32'd0;
  assign a_rvalid = resp_on && !tail.port;
  assign b_rvalid = resp_on && tail.port;
  assign a_rdata = a_rvalid ? rdata : 32'd0;
  assign b_rdata = b_rvalid ? rdata : 32'd0;
  assign a_err = a_rvalid && tail.err;
  assign b_err = b_rvalid && tail.err;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: runs latency-1 and latency-2 arbiters side by side against a byte-level memory model.
module tb_dmem_arbiter;
  localparam int AW = 6;
  logic clk = 1'b0, rst = 1'b1, init_ram = 1'b1;
  always #5 clk = ~clk;
  logic a_valid, a_we, b_valid, b_we;
  logic [2:0] a_funct3, b_funct3;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic a_ready [2], b_ready [2], a_rvalid [2], b_rvalid [2], a_err [2], b_err [2], mem_en [2];
  logic [31:0] a_rdata [2], b_rdata [2], mem_din [2], mem_dout [2];
  logic [AW-1:0] mem_addr [2];
  logic [3:0] mem_wen [2];
  logic [31:0] ram [2][64];
  logic [31:0] stage;

  dmem_arbiter #(.AWIDTH(AW), .MEM_LATENCY(1)) d0 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready[0]), .a_addr(a_addr), .a_we(a_we), .a_funct3(a_funct3),
    .a_wdata(a_wdata), .a_rvalid(a_rvalid[0]), .a_rdata(a_rdata[0]), .a_err(a_err[0]),
    .b_valid(b_valid), .b_ready(b_ready[0]), .b_addr(b_addr), .b_we(b_we), .b_funct3(b_funct3),
    .b_wdata(b_wdata), .b_rvalid(b_rvalid[0]), .b_rdata(b_rdata[0]), .b_err(b_err[0]),
    .mem_en(mem_en[0]), .mem_addr(mem_addr[0]), .mem_wen(mem_wen[0]), .mem_din(mem_din[0]),
    .mem_dout(mem_dout[0]));

  dmem_arbiter #(.AWIDTH(AW), .MEM_LATENCY(2)) d1 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready[1]), .a_addr(a_addr), .a_we(a_we), .a_funct3(a_funct3),
    .a_wdata(a_wdata), .a_rvalid(a_rvalid[1]), .a_rdata(a_rdata[1]), .a_err(a_err[1]),
    .b_valid(b_valid), .b_ready(b_ready[1]), .b_addr(b_addr), .b_we(b_we), .b_funct3(b_funct3),
    .b_wdata(b_wdata), .b_rvalid(b_rvalid[1]), .b_rdata(b_rdata[1]), .b_err(b_err[1]),
    .mem_en(mem_en[1]), .mem_addr(mem_addr[1]), .mem_wen(mem_wen[1]), .mem_din(mem_din[1]),
    .mem_dout(mem_dout[1]));

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din, input logic [3:0] wen);
    logic [31:0] w;
    w = old;
    for (int i = 0; i < 4; i++) if (wen[i]) w[8*i +: 8] = din[8*i +: 8];
    return w;
  endfunction

  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < 64; i++) begin
        ram[0][i] <= 32'd0;
        ram[1][i] <= 32'd0;
      end
    end else begin
      if (mem_en[0]) begin
        ram[0][mem_addr[0]] <= merge(ram[0][mem_addr[0]], mem_din[0], mem_wen[0]);
        mem_dout[0] <= merge(ram[0][mem_addr[0]], mem_din[0], mem_wen[0]);
      end
      if (mem_en[1]) begin
        ram[1][mem_addr[1]] <= merge(ram[1][mem_addr[1]], mem_din[1], mem_wen[1]);
        stage <= merge(ram[1][mem_addr[1]], mem_din[1], mem_wen[1]);
      end
    end
    mem_dout[1] <= stage;
  end

  typedef struct {
    int acc;
    bit port;
    logic [31:0] rdata;
    bit err;
  } exp_t;
  exp_t q[$];
  logic [7:0] mb [256];
  bit lg_b = 1'b1;
  int cyc = 0;
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic bit legal(input bit we, input logic [2:0] f, input logic [31:0] ad);
    if (f[1:0] == 2'd3) return 0;
    if (we && f[2]) return 0;
    if (!we && f[2] && nbytes(f) == 4) return 0;
    return (ad % nbytes(f)) == 0;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f, input logic [31:0] ad);
    int base, n;
    logic [31:0] v, m;
    base = int'(ad[7:2]) * 4;
    n = nbytes(f);
    v = 0;
    for (int i = 0; i < n; i++) v = v + (32'(mb[base + int'(ad[1:0]) + i]) << (8 * i));
    if (n == 4) return v;
    m = (32'd1 << (8 * n)) - 1;
    if (!f[2] && v[8*n-1]) v = v | ~m;
    return v;
  endfunction

  task automatic cycle();
    bit ga, gb, acc, we, ok, found;
    logic [2:0] f;
    logic [31:0] ad, wd;
    exp_t e, ne;
    #1;
    ga = !rst && a_valid && (!b_valid || lg_b);
    gb = !rst && b_valid && !ga;
    acc = ga || gb;
    we = gb ? b_we : a_we;
    f = gb ? b_funct3 : a_funct3;
    ad = gb ? b_addr : a_addr;
    wd = gb ? b_wdata : a_wdata;
    ok = acc && legal(we, f, ad);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d_a_ready", k), 32'(a_ready[k]), 32'(ga));
      chk($sformatf("d%0d_b_ready", k), 32'(b_ready[k]), 32'(gb));
      chk($sformatf("d%0d_mem_en", k), 32'(mem_en[k]), 32'(ok));
      chk($sformatf("d%0d_mem_wen", k), 32'(mem_wen[k]),
          (ok && we) ? (((32'd1 << nbytes(f)) - 1) << ad[1:0]) & 32'hF : 32'd0);
      if (ok) begin
        chk($sformatf("d%0d_mem_addr", k), 32'(mem_addr[k]), 32'(ad[7:2]));
        if (we) chk($sformatf("d%0d_mem_din", k), mem_din[k], wd << (8 * ad[1:0]));
      end else if (rst) begin
        chk($sformatf("d%0d_mem_addr_rst", k), 32'(mem_addr[k]), 32'd0);
        chk($sformatf("d%0d_mem_din_rst", k), mem_din[k], 32'd0);
      end
      found = 0;
      foreach (q[i]) if (q[i].acc == cyc - 1 - k) begin
        found = 1;
        e = q[i];
      end
      chk($sformatf("d%0d_a_rvalid", k), 32'(a_rvalid[k]), 32'(!rst && found && !e.port));
      chk($sformatf("d%0d_b_rvalid", k), 32'(b_rvalid[k]), 32'(!rst && found && e.port));
      if (!rst && found) begin
        chk($sformatf("d%0d_%s_rdata", k, e.port ? "b" : "a"), e.port ? b_rdata[k] : a_rdata[k], e.rdata);
        chk($sformatf("d%0d_%s_err", k, e.port ? "b" : "a"), 32'(e.port ? b_err[k] : a_err[k]), 32'(e.err));
      end else if (rst) begin
        chk($sformatf("d%0d_a_rdata_rst", k), a_rdata[k] | b_rdata[k], 32'd0);
        chk($sformatf("d%0d_err_rst", k), 32'(a_err[k] | b_err[k]), 32'd0);
      end
    end
    while (q.size() > 0 && q[0].acc + 2 <= cyc) void'(q.pop_front());
    @(posedge clk);
    if (rst) begin
      q.delete();
      lg_b = 1'b1;
    end else if (acc) begin
      ne.acc = cyc;
      ne.port = gb;
      ne.err = !ok;
      ne.rdata = (ok && !we) ? load_val(f, ad) : 32'd0;
      if (ok && we)
        for (int i = 0; i < nbytes(f); i++) mb[int'(ad[7:2]) * 4 + int'(ad[1:0]) + i] = wd[8*i +: 8];
      q.push_back(ne);
      lg_b = gb;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_a(input bit v, input bit we, input logic [2:0] f, input logic [31:0] ad, input logic [31:0] wd);
    a_valid = v; a_we = we; a_funct3 = f; a_addr = ad; a_wdata = wd;
  endtask

  task automatic set_b(input bit v, input bit we, input logic [2:0] f, input logic [31:0] ad, input logic [31:0] wd);
    b_valid = v; b_we = we; b_funct3 = f; b_addr = ad; b_wdata = wd;
  endtask

  task automatic idle(input int n);
    set_a(0, 0, 3'd0, 32'd0, 32'd0);
    set_b(0, 0, 3'd0, 32'd0, 32'd0);
    repeat (n) cycle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mb[i] = 8'd0;
    set_a(1, 0, 3'd2, 32'h10, 32'd0);
    set_b(1, 0, 3'd2, 32'h14, 32'd0);
    @(negedge clk);
    repeat (2) cycle();
    rst = 1'b0;
    init_ram = 1'b0;
    idle(1);
    set_a(1, 1, 3'd2, 32'h10, 32'hDEADBEEF); cycle();
    set_a(1, 0, 3'd2, 32'h10, 32'd0); cycle();
    idle(3);
    set_a(1, 1, 3'd0, 32'h13, 32'h000000A5); cycle();
    set_a(1, 0, 3'd0, 32'h13, 32'd0); cycle();
    set_a(1, 0, 3'd4, 32'h13, 32'd0); cycle();
    idle(3);
    set_b(1, 0, 3'd2, 32'h10, 32'd0); cycle();
    set_a(1, 0, 3'd2, 32'h10, 32'd0);
    set_b(1, 0, 3'd4, 32'h13, 32'd0);
    repeat (4) cycle();
    idle(3);
    set_a(1, 0, 3'd1, 32'h21, 32'd0); cycle();
    set_a(1, 1, 3'd2, 32'h22, 32'h12345678); cycle();
    set_a(1, 1, 3'd3, 32'h20, 32'h12345678); cycle();
    set_a(1, 0, 3'd2, 32'h20, 32'd0); cycle();
    idle(3);
    set_a(1, 0, 3'd2, 32'h10, 32'd0); cycle();
    rst = 1'b1;
    set_b(1, 0, 3'd2, 32'h10, 32'd0); cycle();
    rst = 1'b0;
    set_a(1, 0, 3'd2, 32'h10, 32'd0);
    set_b(1, 0, 3'd0, 32'h13, 32'd0);
    repeat (2) cycle();
    idle(3);
    set_b(1, 1, 3'd1, 32'h42, 32'h00008001); cycle();
    set_b(1, 0, 3'd1, 32'h42, 32'd0); cycle();
    set_b(1, 0, 3'd5, 32'h42, 32'd0); cycle();
    idle(3);
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      set_a($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 3'($urandom), $urandom_range(0, 255) | ($urandom & 32'hFFFF_0000), $urandom);
      set_b($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, 3'($urandom), $urandom_range(0, 255), $urandom);
      cycle();
    end
    rst = 1'b0;
    idle(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares one single-port byte-enabled data BRAM between two requesters: port A (CPU load/store unit) and port B (UART program loader / debug DMA). Each accepted request gets a round-robin grant, byte-lane write enables, and a fixed-latency response carrying the lane-aligned, sign/zero-extended load data. The block sits between the CPU MEM stage and the dmem BRAM. It owns all store-lane generation and load extraction for that memory.

Parameters:
AWIDTH, 14, word-address width presented to the BRAM
MEM_LATENCY, 1, BRAM read latency in cycles; legal values 1 or 2

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
a_valid  input  1  port A request valid
a_ready  output  1  port A request accepted this cycle
a_addr  input  32  port A byte address
a_we  input  1  1=store, 0=load
a_funct3  input  3  RV32I funct3: SB/SH/SW or LB/LH/LW/LBU/LHU
a_wdata  input  32  store data, right-justified
a_rvalid  output  1  port A response valid (one cycle)
a_rdata  output  32  extracted load data; 0 for stores
a_err  output  1  misaligned or illegal funct3, qualified by a_rvalid
b_valid, b_ready, b_addr, b_we, b_funct3, b_wdata, b_rvalid, b_rdata, b_err: port B, identical to the port A signals
mem_en  output  1  BRAM enable
mem_addr  output  AWIDTH  word address = byte_addr[AWIDTH+1:2]
mem_wen  output  4  byte write enables
mem_din  output  32  lane-shifted store data
mem_dout  input  32  BRAM read data, valid MEM_LATENCY cycles after mem_en

Behaviour:
- Reset: all outputs 0; pipeline empty; last_grant=B, so A wins the first tie.
- Grant: at most one request per cycle. A single valid requester is granted. When both are valid, the port not granted last wins; last_grant updates only on acceptance.
- x_ready is combinational from valid/last_grant and is never asserted without x_valid. No backpressure from the BRAM: a request is accepted every cycle some valid is high.
- Acceptance cycle drives mem_en=1, mem_addr, mem_din=wdata<<(8*addr[1:0]), and mem_wen.
- mem_wen for SB is 0001<<addr[1:0]. For SH it is 0011<<addr[1:0]. For SW it is 1111. Loads drive 0000.
- Misaligned cases are SH/LH/LHU with addr[0]=1, and SW/LW with addr[1:0]!=0. Illegal funct3 is any funct3 not valid for the opcode.
- A misaligned or illegal request is still accepted and consumes the grant. It drives mem_en=0 and mem_wen=0, and its response carries err=1 with rdata=0.
- Response pipeline: MEM_LATENCY-deep shift register of {valid, port, is_load, funct3, off[1:0], err}.
- The response appears exactly MEM_LATENCY cycles after acceptance on the originating port only: x_rvalid=1 for one cycle. Stores also get the response as a completion ack, with rdata=0.
- Load extraction uses byte = dout>>(8*off). LB sign-extends bit 7. LBU zero-extends. LH sign-extends bit 15. LHU zero-extends. LW passes the word through.
- Back-to-back: a new acceptance every cycle is legal, and responses stream in order with no bubbles.
- A store followed immediately by a load to the same word returns the new data (BRAM write-first/read-after-write across cycles; no forwarding needed).
- Reset mid-operation: in-flight entries are flushed, no rvalid is produced for them, and writes already issued are not undone.
- Both ports target the same address in the same cycle: only the granted one issues, and the other waits.

Test Plan:
1. After reset, A SW addr 0x10 data 0xDEADBEEF, then A LW 0x10 -> mem_wen=1111 on cycle 0; a_rvalid with a_rdata=0xDEADBEEF at acceptance+MEM_LATENCY; b_rvalid stays 0.
2. A SB 0x13 data 0x000000A5, then LB 0x13 and LBU 0x13 -> mem_wen=1000, mem_din=0xA5000000; LB returns 0xFFFFFFA5, LBU returns 0x000000A5.
3. A and B both valid for 4 cycles with loads -> grants alternate A,B,A,B; each rvalid arrives on the correct port in order with no gaps.
4. A LH 0x21 and SW 0x22 -> accepted, mem_en=0, a_err=1, a_rdata=0; BRAM contents unchanged.
5. Load issued, rst asserted in the following cycle -> no rvalid on either port; all outputs 0 next cycle; the first tie after reset goes to A.
6. With MEM_LATENCY=2, B SH 0x42 data 0x8001, then LH/LHU 0x42 -> mem_wen=1100; LH returns 0xFFFF8001 and LHU returns 0x00008001, each two cycles after acceptance.
